// File: rtl/capp_read_scan.sv
// capp_read_scan: banked read/scan unit for the CAPP cell array.
// Scans all banks (LANES cells per clock) and returns either the wired-OR of
// all tagged words (mode 0) or the lowest-index tagged word (mode 1, early stop).
// Optional feature macro: CAPP_READ_COUNT_EN adds the tag_count popcount output.
module capp_read_scan #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4096,
  parameter int LANES = 64,
  localparam int BANKS = DEPTH / LANES,
  localparam int BW = $clog2(BANKS),
  localparam int IW = $clog2(DEPTH),
  localparam int LW = $clog2(LANES)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   start,
  input  logic                   mode,
  output logic                   busy,
  output logic                   done,
  output logic                   bank_rd,
  output logic [BW-1:0]          bank_addr,
  input  logic [LANES*WIDTH-1:0] bank_cells,
  input  logic [LANES-1:0]       bank_tags,
  output logic [WIDTH-1:0]       read_lines,
  output logic                   any_tag,
`ifdef CAPP_READ_COUNT_EN
  output logic [IW:0]            tag_count,
`endif
  output logic [IW-1:0]          first_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic              mode_q;
  logic              vld_p0;
  logic [BW-1:0]     addr_p0;
  logic              consume;
  logic              match1;
  logic              hit_any;
  logic [LW-1:0]     hit_lane;
  logic [WIDTH-1:0]  hit_word;
  logic [WIDTH-1:0]  bank_or;

  function automatic logic [WIDTH-1:0] lane_or(input logic [LANES*WIDTH-1:0] c,
                                               input logic [LANES-1:0] t);
    logic [WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < LANES; i++)
      if (t[i]) acc = acc | c[i*WIDTH +: WIDTH];
    return acc;
  endfunction

`ifdef CAPP_READ_COUNT_EN
  function automatic logic [LW:0] popcount(input logic [LANES-1:0] t);
    logic [LW:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++)
      cnt = cnt + {{LW{1'b0}}, t[i]};
    return cnt;
  endfunction
`endif

  // Return-stage reduction: priority-encode the lowest tagged lane and OR the tagged words.
  always_comb begin
    hit_lane = '0;
    hit_word = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (bank_tags[i]) begin
        hit_lane = LW'(i);
        hit_word = bank_cells[i*WIDTH +: WIDTH];
      end
    end
    hit_any = |bank_tags;
    bank_or = lane_or(bank_cells, bank_tags);
  end

  // Returns only count while scanning; in mode 1 the first hit ends the scan, so the
  // return still in flight lands in DONE and is dropped.
  assign consume = vld_p0 && ((state == SCAN) || (state == DRAIN));
  assign match1  = consume && mode_q && hit_any;

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN: begin
        if (match1) state_nx = DONE;
        else if (bank_addr == BW'(BANKS - 1)) state_nx = DRAIN;
      end
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  // Registered control outputs and the one-stage return valid/address pipe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      bank_rd   <= 1'b0;
      bank_addr <= '0;
      mode_q    <= 1'b0;
      vld_p0    <= 1'b0;
      addr_p0   <= '0;
    end else begin
      busy      <= (state_nx == SCAN) || (state_nx == DRAIN);
      done      <= (state_nx == DONE);
      bank_rd   <= (state_nx == SCAN);
      bank_addr <= ((state == SCAN) && (state_nx == SCAN)) ? bank_addr + 1'b1 : '0;
      if ((state == IDLE) && start) mode_q <= mode;
      vld_p0    <= bank_rd;
      addr_p0   <= bank_addr;
    end
  end

  // Result accumulators: cleared on an accepted start, updated per consumed bank.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      read_lines <= '0;
      any_tag    <= 1'b0;
      first_idx  <= '0;
`ifdef CAPP_READ_COUNT_EN
      tag_count  <= '0;
`endif
    end else if ((state == IDLE) && start) begin
      read_lines <= '0;
      any_tag    <= 1'b0;
      first_idx  <= '0;
`ifdef CAPP_READ_COUNT_EN
      tag_count  <= '0;
`endif
    end else if (consume) begin
      if (mode_q) begin
        if (hit_any) begin
          read_lines <= hit_word;
          any_tag    <= 1'b1;
          first_idx  <= {addr_p0, hit_lane};
        end
      end else begin
        read_lines <= read_lines | bank_or;
        if (hit_any) begin
          any_tag <= 1'b1;
          if (!any_tag) first_idx <= {addr_p0, hit_lane};
        end
      end
`ifdef CAPP_READ_COUNT_EN
      tag_count <= tag_count + (IW + 1)'(popcount(bank_tags));
`endif
    end
  end

endmodule

// File: tb/tb_capp_read_scan.sv
// Self-checking bench for capp_read_scan: default-size instance driven through
// directed scans with a scoreboard, plus a small LANES=8 instance.
module tb_capp_read_scan;

  logic clk = 1'b0;
  logic RST_N = 1'b0;
  always #5 clk = ~clk;

  // Default-size DUT signals
  logic         start = 1'b0, mode = 1'b0;
  logic         busy, done, bank_rd, any_tag;
  logic [5:0]   bank_addr;
  logic [2047:0] bank_cells = '0;
  logic [63:0]  bank_tags = '0;
  logic [31:0]  read_lines;
  logic [11:0]  first_idx;
  logic [12:0]  tag_count;

  // Small DUT signals
  logic         s_start = 1'b0, s_mode = 1'b0;
  logic         s_busy, s_done, s_rd, s_any;
  logic [2:0]   s_addr;
  logic [63:0]  s_cells = '0;
  logic [7:0]   s_tags = '0;
  logic [7:0]   s_rl;
  logic [5:0]   s_fi;
  logic [6:0]   s_cnt;

  logic [31:0] mem [4096];
  logic        tg  [4096];
  logic [7:0]  s_mem [64];

  int errors = 0;
  int checks = 0;
  int scyc;

  typedef struct {
    logic [31:0] rl;
    logic        any;
    logic [11:0] fi;
    int          cnt;
    int          lat;
    int          last_rd;
  } exp_t;
  exp_t sb[$];

  capp_read_scan u_big (
    .CLK(clk), .RST_N(RST_N), .start(start), .mode(mode), .busy(busy), .done(done),
    .bank_rd(bank_rd), .bank_addr(bank_addr), .bank_cells(bank_cells),
    .bank_tags(bank_tags), .read_lines(read_lines), .any_tag(any_tag),
`ifdef CAPP_READ_COUNT_EN
    .tag_count(tag_count),
`endif
    .first_idx(first_idx)
  );

  capp_read_scan #(.WIDTH(8), .DEPTH(64), .LANES(8)) u_sml (
    .CLK(clk), .RST_N(RST_N), .start(s_start), .mode(s_mode), .busy(s_busy), .done(s_done),
    .bank_rd(s_rd), .bank_addr(s_addr), .bank_cells(s_cells),
    .bank_tags(s_tags), .read_lines(s_rl), .any_tag(s_any),
`ifdef CAPP_READ_COUNT_EN
    .tag_count(s_cnt),
`endif
    .first_idx(s_fi)
  );

`ifndef CAPP_READ_COUNT_EN
  assign tag_count = '0;
  assign s_cnt = '0;
`endif

  // Banked storage models with a one-cycle registered read
  always @(posedge clk) begin
    if (bank_rd) begin
      for (int i = 0; i < 64; i++) begin
        bank_cells[i*32 +: 32] <= mem[int'(bank_addr)*64 + i];
        bank_tags[i]           <= tg[int'(bank_addr)*64 + i];
      end
    end
    if (s_rd) begin
      for (int i = 0; i < 8; i++) s_cells[i*8 +: 8] <= s_mem[int'(s_addr)*8 + i];
      s_tags <= 8'hFF;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin mem[i] = '0; tg[i] = 1'b0; end
  endtask

  task automatic tag_cell(input int idx, input logic [31:0] val);
    mem[idx] = val;
    tg[idx]  = 1'b1;
  endtask

  // Reference: walk every cell in index order
  function automatic exp_t model(input logic m);
    exp_t e;
    e.rl = '0; e.any = 1'b0; e.fi = '0; e.cnt = 0;
    for (int i = 0; i < 4096; i++) begin
      if (tg[i]) begin
        if (!e.any) begin
          e.any = 1'b1;
          e.fi  = 12'(i);
          if (m) e.rl = mem[i];
        end
        if (!m) begin
          e.rl = e.rl | mem[i];
          e.cnt++;
        end
      end
    end
    if (m && e.any) begin
      for (int i = 0; i < (int'(e.fi) / 64 + 1) * 64; i++) if (tg[i]) e.cnt++;
      e.lat = int'(e.fi) / 64 + 3;
    end else begin
      e.lat = 66;
    end
    e.last_rd = (m && (e.lat - 1 < 64)) ? e.lat - 1 : 64;
    return e;
  endfunction

  // One scan: push expectation, start, watch until done, compare. pulse_at/rst_at = 0 means unused.
  task automatic run_scan(input logic m, input int pulse_at, input int rst_at);
    exp_t e;
    int cyc, last_rd, addr_bad;
    bit got_done;
    sb.push_back(model(m));
    @(posedge clk); #1; start = 1'b1; mode = m;
    @(posedge clk); #1; start = 1'b0; mode = 1'b0;
    cyc = 1; last_rd = 0; addr_bad = 0; got_done = 1'b0;
    chk("busy_cycle1", 64'(busy), 64'd1);
    while (cyc < 200 && !got_done) begin
      if (bank_rd) begin
        last_rd = cyc;
        if (bank_addr !== 6'(cyc - 1)) addr_bad++;
      end
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (cyc == pulse_at) begin start = 1'b1; mode = ~m; end
        if (cyc == rst_at) begin
          RST_N = 1'b0;
          #2;
          chk("rst_async_outputs",
              {busy, done, bank_rd, bank_addr, read_lines, any_tag, first_idx}, 64'd0);
          chk("rst_async_count", 64'(tag_count), 64'd0);
          e = sb.pop_front();
          @(negedge clk); RST_N = 1'b1;
          return;
        end
        @(posedge clk); #1; start = 1'b0; mode = 1'b0; cyc++;
      end
    end
    chk("done_seen", 64'(got_done), 64'd1);
    e = sb.pop_front();
    chk("done_cycle", 64'(cyc), 64'(e.lat));
    chk("read_lines", 64'(read_lines), 64'(e.rl));
    chk("any_tag", 64'(any_tag), 64'(e.any));
    chk("first_idx", 64'(first_idx), 64'(e.fi));
`ifdef CAPP_READ_COUNT_EN
    chk("tag_count", 64'(tag_count), 64'(e.cnt));
`endif
    chk("bank_rd_last", 64'(last_rd), 64'(e.last_rd));
    chk("bank_addr_seq", 64'(addr_bad), 64'd0);
    chk("busy_at_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("result_hold", 64'(read_lines), 64'(e.rl));
  endtask

  initial begin
    int extra;
    clear_mem();
    for (int i = 0; i < 64; i++) s_mem[i] = 8'(8'h01 << (i % 8));
    #22;
    chk("reset_outputs",
        {busy, done, bank_rd, bank_addr, read_lines, any_tag, first_idx}, 64'd0);
    chk("reset_count", 64'(tag_count), 64'd0);
    @(negedge clk); RST_N = 1'b1;

    // OR mode, nothing tagged
    run_scan(1'b0, 0, 0);
    // OR mode, two tagged cells far apart
    tag_cell(5, 32'h0000_00F0);
    tag_cell(4000, 32'h8000_0001);
    run_scan(1'b0, 0, 0);
    // First responder, two adjacent tagged cells in bank 2
    clear_mem();
    tag_cell(130, 32'hAAAA_AAAA);
    tag_cell(131, 32'h5555_5555);
    tag_cell(700, 32'h0F0F_0000);
    run_scan(1'b1, 0, 0);
    // First responder, match only in the last cell
    clear_mem();
    tag_cell(4095, 32'h1234_5678);
    run_scan(1'b1, 0, 0);
    // First responder, lane 0 of bank 0
    clear_mem();
    tag_cell(0, 32'hDEAD_BEEF);
    tag_cell(3, 32'h0000_0001);
    run_scan(1'b1, 0, 0);
    // First responder, nothing tagged
    clear_mem();
    run_scan(1'b1, 0, 0);

    // Start during a scan is ignored; no second scan follows
    tag_cell(5, 32'h0000_00F0);
    tag_cell(4000, 32'h8000_0001);
    run_scan(1'b0, 10, 0);
    extra = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (done || busy || bank_rd) extra++;
    end
    chk("ignored_start_no_activity", 64'(extra), 64'd0);

    // Asynchronous reset mid-scan, then a normal scan
    run_scan(1'b0, 0, 20);
    run_scan(1'b0, 0, 0);

    // Small configuration, all cells tagged
    @(posedge clk); #1; s_start = 1'b1; s_mode = 1'b0;
    @(posedge clk); #1; s_start = 1'b0;
    scyc = 1;
    while (scyc < 50 && !s_done) begin
      @(posedge clk); #1; scyc++;
    end
    chk("small_done_seen", 64'(s_done), 64'd1);
    chk("small_done_cycle", 64'(scyc), 64'd10);
    chk("small_read_lines", 64'(s_rl), 64'hFF);
    chk("small_any_tag", 64'(s_any), 64'd1);
    chk("small_first_idx", 64'(s_fi), 64'd0);
`ifdef CAPP_READ_COUNT_EN
    chk("small_tag_count", 64'(s_cnt), 64'd64);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capp_read_scan.md
# capp_read_scan

Parametrised, pipelined read unit for the content-addressable parallel processor array. It scans the cell array bank by bank, LANES cells per clock, and accumulates the tagged cells' words. Two read modes: wired-OR of all tagged cells, or first-responder, which returns only the lowest-index tagged cell and stops early. It sits between the array controller, which issues `start`, and the banked cell/tag storage, which has a one-cycle registered read.

## Interface
- `WIDTH`, 32: bits per cell word.
- `DEPTH`, 4096: number of cells; power of two.
- `LANES`, 64: cells per bank read; power of two; must divide `DEPTH`. BANKS = DEPTH/LANES.
- `CLK`, in, 1: single clock, rising edge.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a scan; sampled only while idle.
- `mode`, in, 1: 0 = OR-read, 1 = first-responder; captured with `start`.
- `busy`, out, 1: scan in progress.
- `done`, out, 1: one-cycle pulse; results valid from this cycle onward.
- `bank_rd`, out, 1: bank read strobe.
- `bank_addr`, out, clog2(BANKS): bank index for `bank_rd`.
- `bank_cells`, in, LANES*WIDTH: cell words; lane i is bits [i*WIDTH +: WIDTH]; valid the cycle after `bank_rd`.
- `bank_tags`, in, LANES: tag bits; valid with `bank_cells`.
- `read_lines`, out, WIDTH: read result.
- `any_tag`, out, 1: at least one scanned cell was tagged.
- `first_idx`, out, clog2(DEPTH): global index of the lowest tagged cell; 0 if none.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: `busy`=0. On `start`=1:
  - capture `mode`;
  - clear the accumulators (read_lines, any_tag, first_idx, found flag);
  - go to SCAN with issue counter = 0.
- SCAN: `bank_rd`=1 and `bank_addr`=issue counter, incrementing each cycle.
  - After issuing bank BANKS-1, go to DRAIN.
- Return path: the return of bank k arrives the cycle after it was issued, tracked by a one-stage valid/address pipe.
  - For each returned bank, compute the OR over lanes of (tag AND word) and the lowest set tag lane (priority encoder).
- OR mode:
  - read_lines |= bank OR;
  - any_tag |= |tags;
  - first_idx = k*LANES + lane, written only on the first bank that has a tag.
- First-responder mode: on the first returned bank with a tag:
  - read_lines = word of the lowest tagged lane; any_tag=1; first_idx set;
  - stop issuing, so `bank_rd` drops the next cycle;
  - discard the one in-flight return;
  - go to DONE.
- DRAIN: `bank_rd`=0; absorb the final return, then go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE. Results hold until the next accepted `start`.
- Boundaries:
  - `start` while busy or in DONE is ignored.
  - No tagged cells: read_lines=0, any_tag=0, first_idx=0.
  - Tag in lane 0 of bank 0 gives first_idx=0 with any_tag=1; `any_tag` disambiguates this from the no-tag case.
  - Mode-1 match in the last bank follows the normal DRAIN path.
- Reset, including mid-scan: immediate return to IDLE. All outputs 0: busy, done, bank_rd, bank_addr, read_lines, any_tag, first_idx. In-flight returns are ignored.

## Timing
- Cycle 0: `start` sampled.
- Cycles 1..BANKS: `bank_rd`=1, `bank_addr`=cycle-1.
- Bank k's return is consumed in cycle k+2.
- OR mode: `busy`=1 in cycles 1..BANKS+1; `done` in cycle BANKS+2. Latency is BANKS+2 (66 at defaults).
- First-responder with first tag in bank j: `bank_rd` high in cycles 1..j+2; `done` in cycle j+3 (min 3).
- Back-to-back: the earliest next `start` is the cycle after `done`.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- `CAPP_READ_COUNT_EN` defined: adds output `tag_count`, width clog2(DEPTH)+1.
  - Reset value 0; cleared on start.
  - Adds the popcount of every consumed bank's tags.
  - In mode 1 it counts only the banks consumed up to and including the matching bank, with the discarded return excluded.
- Undefined: no port and no popcount logic. Behaviour is otherwise identical.

## Test plan
- Defaults, OR mode, no tags -> `done` in cycle 66, read_lines=0, any_tag=0, first_idx=0, tag_count=0.
- OR mode, cell 5=0x0000_00F0 and cell 4000=0x8000_0001 tagged -> read_lines=0x8000_00F1, first_idx=5, tag_count=2, `done` in cycle 66.
- Mode 1, cells 130 (0xAAAA_AAAA) and 131 (0x5555_5555) tagged -> read_lines=0xAAAA_AAAA, first_idx=130, `bank_rd` last high in cycle 4, `done` in cycle 5.
- Mode 1, only cell 4095=0x1234_5678 tagged -> read_lines=0x1234_5678, first_idx=4095, `done` in cycle 66.
- `start` pulsed in cycle 10 of a scan -> ignored, single `done`. `RST_N` low in cycle 20 of a second scan -> all outputs 0 asynchronously. A new `start` after release completes normally.
- LANES=8, DEPTH=64, WIDTH=8, OR mode, all cells tagged with 0x01<<(i%8) -> read_lines=0xFF, `done` in cycle 10, tag_count=64.
